gpu_framebuffer_arbiter: RTL

Sequences and shares the single-port GPU framebuffer between three masters: display scanout reads, CPU read/write accesses, and a built-in clear engine.
- Issues at most one framebuffer operation per clock.
- Drives the framebuffer address/data/write lines from posedge registers.
- Captures read data returned on the framebuffer's negedge.

---
 rtl/gpu_framebuffer_arbiter_if.sv | 50 +++++
 rtl/gpu_framebuffer_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/gpu_framebuffer_arbiter_if.sv
// Bundle between the framebuffer arbiter, its three requesters
// and the single-port framebuffer memory.
interface gpu_framebuffer_arbiter_if #(
  parameter int AW = 11
);
  logic [AW-1:0] fb_address;
  logic [63:0]   fb_in;
  logic          fb_write;
  logic [63:0]   fb_out;

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic [63:0]   disp_data;
  logic          disp_valid;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [63:0]   cpu_wdata;
  logic          cpu_ack;
  logic [63:0]   cpu_rdata;
  logic          cpu_rvalid;

  logic          clear_start;
  logic [63:0]   clear_value;
  logic          clear_busy;

  modport slave (
    input  fb_out,
    input  disp_req, disp_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  clear_start, clear_value,
    output fb_address, fb_in, fb_write,
    output disp_ack, disp_data, disp_valid,
    output cpu_ack, cpu_rdata, cpu_rvalid,
    output clear_busy
  );

  modport master (
    output fb_out,
    output disp_req, disp_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output clear_start, clear_value,
    input  fb_address, fb_in, fb_write,
    input  disp_ack, disp_data, disp_valid,
    input  cpu_ack, cpu_rdata, cpu_rvalid,
    input  clear_busy
  );
endinterface

// File: rtl/gpu_framebuffer_arbiter.sv
// Shares one single-port framebuffer between display scanout,
// CPU accesses and a fill engine; one operation per clock.
module gpu_framebuffer_arbiter #(
  parameter int framebufferSize        = 1200,
  parameter int framebufferSizeAddress = 11
) (
  input  logic clock,
  input  logic reset,
  gpu_framebuffer_arbiter_if.slave bus
);
  localparam int AW = framebufferSizeAddress;
  localparam logic [AW-1:0] LAST = AW'(framebufferSize - 1);
  localparam logic [AW:0]   SIZE = (AW+1)'(framebufferSize);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_fb_address;
  logic [63:0]   r_clr_val;
  logic [63:0]   r_fb_in;
  logic [63:0]   r_disp_data;
  logic [63:0]   r_cpu_rdata;
  logic          r_fb_write;
  logic          r_disp_valid;
  logic          r_cpu_rvalid;
  logic          r_tag_vld;
  logic          r_tag_cpu;
  logic          r_tag_zero;

  logic w_disp_gnt;
  logic w_clr_gnt;
  logic w_cpu_gnt;
  logic w_disp_in;
  logic w_cpu_in;

  assign w_disp_gnt = bus.disp_req;
  assign w_clr_gnt  = (r_state == CLEAR) && !bus.disp_req;
  assign w_cpu_gnt  = bus.cpu_req && !bus.disp_req &&
                      (r_state == IDLE);
  assign w_disp_in  = {1'b0, bus.disp_addr} < SIZE;
  assign w_cpu_in   = {1'b0, bus.cpu_addr} < SIZE;

  assign bus.disp_ack   = bus.disp_req;
  assign bus.cpu_ack    = w_cpu_gnt;
  assign bus.clear_busy = (r_state == CLEAR);
  assign bus.fb_address = r_fb_address;
  assign bus.fb_in      = r_fb_in;
  assign bus.fb_write   = r_fb_write;
  assign bus.disp_data  = r_disp_data;
  assign bus.disp_valid = r_disp_valid;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_rvalid = r_cpu_rvalid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_clr_val    <= '0;
      r_fb_address <= '0;
      r_fb_in      <= '0;
      r_fb_write   <= 1'b0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_tag_vld    <= 1'b0;
      r_tag_cpu    <= 1'b0;
      r_tag_zero   <= 1'b0;
    end else begin
      r_fb_write   <= 1'b0;
      r_tag_vld    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_cpu_rvalid <= 1'b0;

      // fb_out was produced at the negedge of the issuing cycle
      if (r_tag_vld) begin
        if (r_tag_cpu) begin
          r_cpu_rdata  <= r_tag_zero ? '0 : bus.fb_out;
          r_cpu_rvalid <= 1'b1;
        end else begin
          r_disp_data  <= r_tag_zero ? '0 : bus.fb_out;
          r_disp_valid <= 1'b1;
        end
      end

      unique case (1'b1)
        w_disp_gnt: begin
          r_fb_address <= bus.disp_addr;
          r_tag_vld    <= 1'b1;
          r_tag_cpu    <= 1'b0;
          r_tag_zero   <= !w_disp_in;
        end
        w_clr_gnt: begin
          r_fb_address <= r_cnt;
          r_fb_in      <= r_clr_val;
          r_fb_write   <= 1'b1;
          r_cnt        <= r_cnt + 1'b1;
          if (r_cnt == LAST)
            r_state <= IDLE;
        end
        w_cpu_gnt: begin
          r_fb_address <= bus.cpu_addr;
          if (bus.cpu_we) begin
            r_fb_in    <= bus.cpu_wdata;
            r_fb_write <= w_cpu_in;
          end else begin
            r_tag_vld  <= 1'b1;
            r_tag_cpu  <= 1'b1;
            r_tag_zero <= !w_cpu_in;
          end
        end
        default: ;
      endcase

      if (r_state == IDLE && bus.clear_start) begin
        r_state   <= CLEAR;
        r_cnt     <= '0;
        r_clr_val <= bus.clear_value;
      end
    end
  end
endmodule
